// File: rtl/dac_dma_pkg.sv
// Shared types and helpers for the DAC DMA unpacker: sample geometry, popcount
// and the mapping from an enabled channel to its word slot within a sample set.
package dac_dma_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned SAMP_W    = 16;
    localparam int unsigned DATA_W    = NUM_CH * SAMP_W;
    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned BUF_W     = BUF_DEPTH * SAMP_W;

    typedef logic [SAMP_W-1:0] word_t;

    function automatic logic [2:0] popcount4(input logic [NUM_CH-1:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Enabled channels take words in ascending channel order, so a channel's
    // slot is the number of enabled channels below it.
    function automatic logic [1:0] chan_slot(input logic [NUM_CH-1:0] m, input int c);
        logic [1:0] s;
        s = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (i < c && m[i]) s = s + 2'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/dac_word_buffer.sv
// Eight-word shift buffer: word 0 is the oldest. Pops remove from the bottom
// before the beat's four words are appended above the survivors.
module dac_word_buffer
    import dac_dma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [2:0]        pop_n_i,
    output logic [3:0]        level_o,
    output logic [DATA_W-1:0] head_o
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [3:0]       level_q, level_d;

    // Slots at or above the level are kept zero so appends can simply OR in.
    always_comb begin
        buf_d   = buf_q;
        level_d = level_q;
        if (pop_i) begin
            buf_d   = buf_q >> (SAMP_W * pop_n_i);
            level_d = level_q - {1'b0, pop_n_i};
        end
        if (push_i) begin
            buf_d   = buf_d | (BUF_W'(push_data_i) << (SAMP_W * level_d));
            level_d = level_d + 4'd4;
        end
        if (flush_i) begin
            buf_d   = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            level_q <= '0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign head_o  = buf_q[DATA_W-1:0];

endmodule

// File: rtl/dac_dma_unpacker.sv
// Unpacks 64-bit DMA beats into per-channel DAC sample sets on each strobe,
// flagging underflow when too few words are buffered.
module dac_dma_unpacker
    import dac_dma_pkg::*;
#(
    parameter bit UnderflowHold = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] enable_mask_i,
    input  logic [DATA_W-1:0] s_axis_tdata_i,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    input  logic              s_axis_tlast_i,
    input  logic              dac_strobe_i,
    output logic [DATA_W-1:0] dac_data_o,
    output logic              dac_data_valid_o,
    output logic              underflow_o,
    output logic              underflow_sticky_o,
    input  logic              underflow_clr_i,
    output logic [3:0]        fill_level_o
);

    logic              enable_q, run_q, valid_q, uf_q, sticky_q;
    logic [NUM_CH-1:0] mask_q;
    logic [DATA_W-1:0] dac_data_q, last_q;
    logic [DATA_W-1:0] head, set;
    logic [3:0]        level;
    logic [2:0]        n_words;
    logic              push, strobe_act, pop, uf;
    logic              unused_tlast;

    assign unused_tlast    = s_axis_tlast_i;
    assign n_words         = popcount4(mask_q);
    assign s_axis_tready_o = run_q && (level <= 4'd4);
    assign push            = s_axis_tvalid_i && s_axis_tready_o;
    assign strobe_act      = dac_strobe_i && run_q && enable_i;
    assign pop             = strobe_act && (level >= {1'b0, n_words});
    assign uf              = strobe_act && (level < {1'b0, n_words});

    dac_word_buffer u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (!enable_i),
        .push_i      (push),
        .push_data_i (s_axis_tdata_i),
        .pop_i       (pop),
        .pop_n_i     (n_words),
        .level_o     (level),
        .head_o      (head)
    );

    always_comb begin
        set = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            int unsigned slot;
            slot = 32'(chan_slot(mask_q, c));
            if (mask_q[c]) set[c*SAMP_W +: SAMP_W] = head[slot*SAMP_W +: SAMP_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q   <= 1'b0;
            run_q      <= 1'b0;
            mask_q     <= '0;
            valid_q    <= 1'b0;
            uf_q       <= 1'b0;
            sticky_q   <= 1'b0;
            dac_data_q <= '0;
            last_q     <= '0;
        end else begin
            enable_q <= enable_i;
            if (enable_i && !enable_q) begin
                mask_q <= enable_mask_i;
                run_q  <= (popcount4(enable_mask_i) != 3'd0);
            end else if (!enable_i) begin
                run_q <= 1'b0;
            end
            valid_q <= pop || uf;
            uf_q    <= uf;
            if (!enable_i) begin
                dac_data_q <= '0;
                last_q     <= '0;
            end else if (pop) begin
                dac_data_q <= set;
                last_q     <= set;
            end else if (uf) begin
                dac_data_q <= UnderflowHold ? last_q : '0;
            end
            // A fresh underflow wins over a simultaneous clear.
            if (uf) sticky_q <= 1'b1;
            else if (underflow_clr_i) sticky_q <= 1'b0;
        end
    end

    assign dac_data_o         = dac_data_q;
    assign dac_data_valid_o   = valid_q;
    assign underflow_o        = uf_q;
    assign underflow_sticky_o = sticky_q;
    assign fill_level_o       = level;

endmodule

// File: tb/tb_dac_dma_unpacker.sv
// Scoreboard bench for dac_dma_unpacker: stimulus queues expected sample sets,
// negedge monitors compare them against a zero-fill and a hold-last instance.
module tb_dac_dma_unpacker;

    typedef struct {
        logic [63:0] data;
        logic        uf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enable, hold_phase, tvalid, tlast, strobe, clr;
    logic [3:0]  mask;
    logic [63:0] tdata;
    logic        tready, valid, uf, sticky;
    logic [63:0] data;
    logic [3:0]  fill;
    logic        h_tready, h_valid, h_uf, h_sticky;
    logic [63:0] h_data;
    logic [3:0]  h_fill;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t qh[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_dma_unpacker #(.UnderflowHold(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .enable_mask_i(mask),
        .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready),
        .s_axis_tlast_i(tlast), .dac_strobe_i(strobe), .dac_data_o(data),
        .dac_data_valid_o(valid), .underflow_o(uf), .underflow_sticky_o(sticky),
        .underflow_clr_i(clr), .fill_level_o(fill)
    );

    dac_dma_unpacker #(.UnderflowHold(1'b1)) dut_hold (
        .clk_i(clk), .rst_i(rst), .enable_i(enable && hold_phase), .enable_mask_i(mask),
        .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid), .s_axis_tready_o(h_tready),
        .s_axis_tlast_i(tlast), .dac_strobe_i(strobe), .dac_data_o(h_data),
        .dac_data_valid_o(h_valid), .underflow_o(h_uf), .underflow_sticky_o(h_sticky),
        .underflow_clr_i(clr), .fill_level_o(h_fill)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            fail_msg($sformatf("main_missing: no output by cycle %0d, expected %h", e.due, e.data));
        end
        if (valid) begin
            if (q.size() == 0) fail_msg($sformatf("main_unexpected: got valid data %h", data));
            else begin
                e = q.pop_front();
                check("main_latency", 64'(cyc), 64'(e.due));
                check("main_data", data, e.data);
                check("main_underflow", {63'b0, uf}, {63'b0, e.uf});
            end
        end else if (uf) fail_msg("main_underflow_without_valid");
    end

    always @(negedge clk) begin
        exp_t e;
        if (qh.size() > 0 && qh[0].due < cyc) begin
            e = qh.pop_front();
            fail_msg($sformatf("hold_missing: no output by cycle %0d, expected %h", e.due, e.data));
        end
        if (h_valid) begin
            if (qh.size() == 0) fail_msg($sformatf("hold_unexpected: got valid data %h", h_data));
            else begin
                e = qh.pop_front();
                check("hold_latency", 64'(cyc), 64'(e.due));
                check("hold_data", h_data, e.data);
                check("hold_underflow", {63'b0, h_uf}, {63'b0, e.uf});
            end
        end else if (h_uf) fail_msg("hold_underflow_without_valid");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] m);
        mask   = m;
        enable = 1'b1;
        tick();
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
    endtask

    task automatic beat(input logic [63:0] d);
        tvalid = 1'b1;
        tdata  = d;
        check("tready_for_beat", {63'b0, tready}, 64'd1);
        tick();
        tvalid = 1'b0;
    endtask

    task automatic strobe_exp(input logic [63:0] e, input logic u, input logic [63:0] eh,
                              input logic c);
        exp_t x;
        strobe = 1'b1;
        clr    = c;
        x.data = e;
        x.uf   = u;
        x.due  = cyc + 1;
        q.push_back(x);
        if (hold_phase) begin
            x.data = eh;
            qh.push_back(x);
        end
        tick();
        strobe = 1'b0;
        clr    = 1'b0;
    endtask

    function automatic logic [63:0] mkbeat(input int w);
        return {16'(w + 3), 16'(w + 2), 16'(w + 1), 16'(w)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; hold_phase = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        strobe = 1'b0; clr = 1'b0; mask = 4'h0; tdata = '0;
        repeat (3) tick();
        check("rst_tready", {63'b0, tready}, 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_valid", {63'b0, valid}, 64'd0);
        check("rst_underflow", {63'b0, uf}, 64'd0);
        check("rst_sticky", {63'b0, sticky}, 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        rst = 1'b0;
        tick();

        // Two channels, two beats, four sets.
        start(4'h3);
        beat(64'h0004_0003_0002_0001);
        beat(64'h0008_0007_0006_0005);
        check("t1_fill_full", 64'(fill), 64'd8);
        check("t1_tready_full", {63'b0, tready}, 64'd0);
        strobe_exp(64'h0000_0000_0002_0001, 1'b0, '0, 1'b0);
        strobe_exp(64'h0000_0000_0004_0003, 1'b0, '0, 1'b0);
        strobe_exp(64'h0000_0000_0006_0005, 1'b0, '0, 1'b0);
        strobe_exp(64'h0000_0000_0008_0007, 1'b0, '0, 1'b0);
        tick();
        check("t1_fill_empty", 64'(fill), 64'd0);
        check("t1_sticky", {63'b0, sticky}, 64'd0);
        stop();

        // Three channels (0,2,3): sets straddle beat boundaries.
        start(4'hD);
        beat(64'h0004_0003_0002_0001);
        beat(64'h0008_0007_0006_0005);
        strobe_exp(64'h0003_0002_0000_0001, 1'b0, '0, 1'b0);
        check("t2_fill_5", 64'(fill), 64'd5);
        strobe_exp(64'h0006_0005_0000_0004, 1'b0, '0, 1'b0);
        check("t2_fill_2", 64'(fill), 64'd2);
        beat(64'h000C_000B_000A_0009);
        strobe_exp(64'h0009_0008_0000_0007, 1'b0, '0, 1'b0);
        strobe_exp(64'h000C_000B_0000_000A, 1'b0, '0, 1'b0);
        tick();
        check("t2_fill_empty", 64'(fill), 64'd0);
        stop();

        // Empty mask keeps the block idle.
        start(4'h0);
        tvalid = 1'b1;
        tdata  = 64'h1111_2222_3333_4444;
        strobe = 1'b1;
        check("t0_tready", {63'b0, tready}, 64'd0);
        tick();
        tick();
        tvalid = 1'b0;
        strobe = 1'b0;
        tick();
        check("t0_fill", 64'(fill), 64'd0);
        stop();

        // Underflow with nothing buffered, then sticky clear.
        start(4'hF);
        strobe_exp(64'd0, 1'b1, '0, 1'b0);
        strobe_exp(64'd0, 1'b1, '0, 1'b0);
        tick();
        check("t3_sticky_set", {63'b0, sticky}, 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_sticky_clr", {63'b0, sticky}, 64'd0);
        stop();

        // Throttled supply, strobe on most cycles; words must stay consecutive.
        start(4'hF);
        begin
            int lvl = 0;
            int bw  = 16'h101;
            int rw  = 16'h101;
            for (int i = 0; i < 24; i++) begin
                logic tv, s, pushed;
                exp_t x;
                tv     = !(i inside {8, 9, 14, 18, 19, 20});
                s      = (i >= 3);
                tvalid = tv;
                tdata  = mkbeat(bw);
                strobe = s;
                check($sformatf("t4_tready_%0d", i), {63'b0, tready}, {63'b0, (lvl <= 4)});
                check($sformatf("t4_fill_%0d", i), 64'(fill), 64'(lvl));
                pushed = tv && (lvl <= 4);
                x.due  = cyc + 1;
                if (s) begin
                    if (lvl >= 4) begin
                        x.data = mkbeat(rw);
                        x.uf   = 1'b0;
                        rw    += 4;
                        lvl   -= 4;
                    end else begin
                        x.data = '0;
                        x.uf   = 1'b1;
                    end
                    q.push_back(x);
                end
                if (pushed) begin
                    bw  += 4;
                    lvl += 4;
                end
                tick();
            end
            tvalid = 1'b0;
            strobe = 1'b0;
            tick();
            check("t4_sticky", {63'b0, sticky}, 64'd1);
        end
        stop();

        // Disable mid-stream at level 6 with a beat presented.
        start(4'h3);
        beat(64'h0014_0013_0012_0011);
        beat(64'h0018_0017_0016_0015);
        strobe_exp(64'h0000_0000_0012_0011, 1'b0, '0, 1'b0);
        check("t5_fill_6", 64'(fill), 64'd6);
        tvalid = 1'b1;
        tdata  = 64'h00FF_00FE_00FD_00FC;
        enable = 1'b0;
        tick();
        tvalid = 1'b0;
        check("t5_fill_flushed", 64'(fill), 64'd0);
        check("t5_tready_off", {63'b0, tready}, 64'd0);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        check("t5_data_zero", data, 64'd0);
        start(4'h1);
        beat(64'h0034_0033_0032_0031);
        strobe_exp(64'h0000_0000_0000_0031, 1'b0, '0, 1'b0);
        strobe_exp(64'h0000_0000_0000_0032, 1'b0, '0, 1'b0);

        // Reset with a beat handshaken in the same cycle discards it.
        rst    = 1'b1;
        enable = 1'b0;
        tvalid = 1'b1;
        tdata  = 64'h0044_0043_0042_0041;
        tick();
        rst    = 1'b0;
        tvalid = 1'b0;
        check("t5_rst_fill", 64'(fill), 64'd0);
        check("t5_rst_tready", {63'b0, tready}, 64'd0);
        check("t5_rst_data", data, 64'd0);
        start(4'h1);
        beat(64'h0054_0053_0052_0051);
        strobe_exp(64'h0000_0000_0000_0051, 1'b0, '0, 1'b0);
        tick();
        stop();

        // Underflow coinciding with clear; hold instance repeats the last set.
        hold_phase = 1'b1;
        start(4'h3);
        beat(64'h0074_0073_0072_0071);
        strobe_exp(64'h0000_0000_0072_0071, 1'b0, 64'h0000_0000_0072_0071, 1'b0);
        strobe_exp(64'h0000_0000_0074_0073, 1'b0, 64'h0000_0000_0074_0073, 1'b0);
        check("t6_sticky_before", {63'b0, sticky}, 64'd0);
        strobe_exp(64'd0, 1'b1, 64'h0000_0000_0074_0073, 1'b1);
        check("t6_sticky_kept", {63'b0, sticky}, 64'd1);
        check("t6_hold_sticky", {63'b0, h_sticky}, 64'd1);
        strobe_exp(64'd0, 1'b1, 64'h0000_0000_0074_0073, 1'b0);
        beat(64'h0084_0083_0082_0081);
        strobe_exp(64'h0000_0000_0082_0081, 1'b0, 64'h0000_0000_0082_0081, 1'b0);
        tick();
        tick();
        stop();
        hold_phase = 1'b0;
        tick();

        check("main_queue_drained", 64'(q.size()), 64'd0);
        check("hold_queue_drained", 64'(qh.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_dma_unpacker.md
Name: dac_dma_unpacker

Overview:
Receive side of the DAC DMA stream. It accepts 64-bit AXI-Stream beats, each carrying four 16-bit sample words, from the DAC DMA. It unpacks them into per-channel DAC samples according to the channel enable mask, one sample set per DAC sample strobe. It detects and reports underflow when the DMA cannot keep up. It sits between the DAC DMA AXIS slave and the DAC sample interface inside the default block.

Parameters:
NUM_CH, 4, number of DAC channels (fixed 4 in this revision)
SAMP_W, 16, bits per channel sample
DATA_W, 64, AXIS data width; must equal NUM_CH*SAMP_W
UNDERFLOW_HOLD, 0, 0: output zeros on underflow; 1: repeat the last good sample set

Ports:
clk  in  1  single clock for stream and DAC side
rst  in  1  synchronous, active-high reset
enable  in  1  run control; low flushes the buffer
enable_mask  in  4  channel enables, captured on the rising edge of enable
s_axis_tdata  in  64  word k = tdata[16k+15:16k]; word 0 is consumed first
s_axis_tvalid  in  1  AXIS valid
s_axis_tready  out  1  AXIS ready
s_axis_tlast  in  1  accepted and ignored
dac_strobe  in  1  one-cycle sample request from the DAC
dac_data  out  64  channel c = dac_data[16c+15:16c]
dac_data_valid  out  1  one-cycle qualifier for dac_data
underflow  out  1  one-cycle pulse per underflowed strobe
underflow_sticky  out  1  latched underflow flag
underflow_clr  in  1  clears underflow_sticky
fill_level  out  4  words currently buffered (0..8)

Behaviour:
- Reset: tready=0, dac_data=0, dac_data_valid=0, underflow=0, underflow_sticky=0, fill_level=0, captured mask=0, run=0.
- Capture:
  - N = popcount(captured mask).
  - On enable 0->1: capture enable_mask and set run=1 if N>0.
  - Mask changes while enable=1 are ignored.
  - N=0: block stays idle. No tready, no outputs, no underflow.
- Buffer: 8 x 16-bit word buffer.
  - s_axis_tready = run && fill_level<=4, computed combinationally from the registered level.
  - Beat accepted when tvalid && tready: all 4 words are appended.
- Pop: on dac_strobe with run=1 and fill_level>=N, the N oldest words are removed.
  - Words map in order to the enabled channels, ascending channel index.
  - Disabled channels output 0.
  - Next cycle: dac_data = assembled set, dac_data_valid=1. Latency is 1 cycle from strobe.
- Same-cycle push and pop:
  - The pop sees only the words present before the push.
  - level_next = level + 4*push - N*pop.
  - N=3 spans beats correctly.
- Underflow: dac_strobe with run=1 and fill_level<N.
  - No words consumed; a partial remainder stays buffered.
  - Next cycle: dac_data_valid=1, dac_data = 0 (or the last set if UNDERFLOW_HOLD=1), underflow=1.
  - underflow_sticky is set.
- Sticky clear: underflow_clr clears underflow_sticky. If underflow_clr and a new underflow occur in the same cycle, underflow_sticky stays 1.
- Disable: enable=0 sets run=0 and flushes fill_level to 0 next cycle.
  - tready=0.
  - Strobes are ignored: dac_data_valid=0, no underflow.
  - dac_data holds 0.
  - A beat handshaken in the cycle enable falls is discarded.
- Reset mid-operation: same as the reset state, including a discarded in-flight beat. The first sample set after re-enable comes only from new beats.

Decomposition:
- Package dac_dma_pkg holds: SAMP_W, NUM_CH, word type logic[SAMP_W-1:0], popcount4 function, mask-to-channel-slot mapping function.
- Sub-module dac_word_buffer: 8-word shift buffer with push4/popN, level output, flush.
- Top-level logic: capture, strobe, underflow and output registers.

Test Plan:
- Mask 4'h3, beats 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, 4 strobes -> dac_data 0x0000_0000_0002_0001, then ..._0004_0003, ..._0006_0005, ..._0008_0007; each appears 1 cycle after its strobe; no underflow.
- Mask 4'hD (N=3), three beats of words 1..12, 4 strobes -> ch0/ch2/ch3 = (1,2,3), (4,5,6), (7,8,9), (10,11,12); ch1=0 throughout; fill_level returns to 0.
- Mask 4'hF, no beats, 2 strobes -> two dac_data_valid cycles with dac_data=0 and underflow pulses; underflow_sticky=1; assert underflow_clr -> sticky=0 next cycle.
- Mask 4'hF, tvalid held high, tready throttled, strobe every cycle -> tready never asserted at level>4; strobes pushed beyond supply produce underflow; output sequence is gap-free with no lost or duplicated words.
- Mid-stream enable=0 with level=6 and a beat in flight -> level=0 next cycle, tready=0, strobes give no valid; re-enable with mask 4'h1 -> first output is word 0 of the next new beat.
- Strobe coinciding with underflow_clr and level<N -> underflow pulse and sticky remains 1; UNDERFLOW_HOLD=1 -> the underflowed output repeats the previous set.
